// File: rtl/stream_xbar_sched_pkg.sv
// Shared helpers for the weighted round-robin crossbar scheduler.
// Supports crossbars with up to MaxNumInp inputs.
package stream_xbar_sched_pkg;

    localparam int MaxNumInp   = 64;
    localparam int MaxIdxWidth = 6;

    // Circular first-nonzero search starting after p; returns p when the mask is empty.
    function automatic int next_nonzero_idx(input logic [MaxNumInp-1:0] nz_mask,
                                            input int num_inp,
                                            input int p);
        int result;
        int k;
        result = p;
        for (int s = MaxNumInp; s >= 1; s--) begin
            if (s <= num_inp) begin
                k = (p + s) % num_inp;
                if (nz_mask[k[MaxIdxWidth-1:0]]) begin
                    result = k;
                end
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/stream_xbar_wrr_lane.sv
// One scheduler lane: pointer/burst-counter state machine for a single crossbar output.
// The favoured index only moves on completed handshakes.
module stream_xbar_wrr_lane
    import stream_xbar_sched_pkg::*;
#(
    parameter int NumInp      = 1,
    parameter int WeightWidth = 4,
    parameter int IdxWidth    = 1
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          flush_i,
    input  logic [NumInp*WeightWidth-1:0] weight_i,
    input  logic [IdxWidth-1:0]           idx_i,
    input  logic                          hs_i,
    output logic [IdxWidth-1:0]           rr_o
);

    typedef struct packed {
        logic [IdxWidth-1:0]    ptr;
        logic [WeightWidth-1:0] cnt;
    } lane_state_t;

    localparam int NumSlots = 1 << IdxWidth;
    localparam logic [WeightWidth:0]   CntOne = 1;
    localparam logic [WeightWidth-1:0] WOne   = 1;

    lane_state_t state_q, state_d;

    logic [WeightWidth-1:0] weight_slot [NumSlots];
    logic [MaxNumInp-1:0]   nz_mask;
    logic [WeightWidth-1:0] w_ptr, w_idx;
    logic [WeightWidth:0]   cnt_inc;

    // Unused index slots read as weight 0, so out-of-range indices never win priority.
    for (genvar k = 0; k < NumSlots; k++) begin : g_slot
        if (k < NumInp) begin : g_used
            assign weight_slot[k] = weight_i[k*WeightWidth +: WeightWidth];
        end else begin : g_pad
            assign weight_slot[k] = '0;
        end
    end

    for (genvar k = 0; k < MaxNumInp; k++) begin : g_mask
        if (k < NumInp) begin : g_used
            assign nz_mask[k] = |weight_i[k*WeightWidth +: WeightWidth];
        end else begin : g_pad
            assign nz_mask[k] = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every lane samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= '0;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        w_ptr   = weight_slot[state_q.ptr];
        w_idx   = weight_slot[idx_i];
        cnt_inc = {1'b0, state_q.cnt} + CntOne;
        if (flush_i) begin
            state_d = '0;
        end else if (hs_i) begin
            if (idx_i == state_q.ptr) begin
                if (cnt_inc >= {1'b0, w_ptr}) begin
                    state_d.ptr = IdxWidth'(next_nonzero_idx(nz_mask, NumInp, int'(state_q.ptr)));
                    state_d.cnt = '0;
                end else begin
                    state_d.cnt = cnt_inc[WeightWidth] ? '1 : cnt_inc[WeightWidth-1:0];
                end
            end else if (w_idx != '0) begin
                // Arbiter served a non-favoured input: priority follows the winner.
                if (w_idx == WOne) begin
                    state_d.ptr = IdxWidth'(next_nonzero_idx(nz_mask, NumInp, int'(idx_i)));
                    state_d.cnt = '0;
                end else begin
                    state_d.ptr = idx_i;
                    state_d.cnt = WOne;
                end
            end
        end
    end

    always_comb begin
        rr_o = state_q.ptr;
    end

endmodule

// File: rtl/stream_xbar_wrr_sched.sv
// Weighted round-robin priority scheduler beside the stream crossbar.
// One independent lane per output drives that output's external round-robin pointer.
module stream_xbar_wrr_sched
    import stream_xbar_sched_pkg::*;
#(
    parameter  int NumInp      = 1,
    parameter  int NumOut      = 1,
    parameter  int WeightWidth = 4,
    localparam int IdxWidth    = (NumInp > 1) ? $clog2(NumInp) : 1
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          flush_i,
    input  logic [NumInp*WeightWidth-1:0] weight_i,
    input  logic [NumOut*IdxWidth-1:0]    out_idx_i,
    input  logic [NumOut-1:0]             out_hs_i,
    output logic [NumOut*IdxWidth-1:0]    rr_o
);

    for (genvar j = 0; j < NumOut; j++) begin : g_lane
        stream_xbar_wrr_lane #(
            .NumInp      (NumInp),
            .WeightWidth (WeightWidth),
            .IdxWidth    (IdxWidth)
        ) u_lane (
            .clk_i    (clk_i),
            .rst_i    (rst_i),
            .flush_i  (flush_i),
            .weight_i (weight_i),
            .idx_i    (out_idx_i[j*IdxWidth +: IdxWidth]),
            .hs_i     (out_hs_i[j]),
            .rr_o     (rr_o[j*IdxWidth +: IdxWidth])
        );

`ifndef SYNTHESIS
        a_idx_in_range : assert property (@(posedge clk_i) disable iff (rst_i)
            out_hs_i[j] |-> (int'(out_idx_i[j*IdxWidth +: IdxWidth]) < NumInp))
            else $error("out_idx_i out of range on output %0d", j);

        a_rr_stable : assert property (@(posedge clk_i) disable iff (rst_i)
            (!out_hs_i[j] && !flush_i) |=> $stable(rr_o[j*IdxWidth +: IdxWidth]))
            else $error("rr_o changed without handshake on output %0d", j);
`endif
    end

endmodule

// File: tb/tb_stream_xbar_wrr_sched.sv
// Directed bench for stream_xbar_wrr_sched with 4 inputs and 2 outputs.
module tb_stream_xbar_wrr_sched;

    localparam int NumInp      = 4;
    localparam int NumOut      = 2;
    localparam int WeightWidth = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [15:0] weight;
    logic [3:0]  out_idx;
    logic [1:0]  out_hs;
    logic [3:0]  rr;

    int n_cmp  = 0;
    int n_fail = 0;

    stream_xbar_wrr_sched #(
        .NumInp      (NumInp),
        .NumOut      (NumOut),
        .WeightWidth (WeightWidth)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .flush_i   (flush),
        .weight_i  (weight),
        .out_idx_i (out_idx),
        .out_hs_i  (out_hs),
        .rr_o      (rr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_w(input logic [3:0] w0, input logic [3:0] w1,
                         input logic [3:0] w2, input logic [3:0] w3);
        weight = {w3, w2, w1, w0};
    endtask

    // Drive one cycle of inputs, let the edge commit, sample 1 time unit later.
    task automatic step(input logic h0, input logic [1:0] i0,
                        input logic h1, input logic [1:0] i1, input logic fl);
        out_hs  = {h1, h0};
        out_idx = {i1, i0};
        flush   = fl;
        @(posedge clk);
        #1;
        out_hs = 2'b00;
        flush  = 1'b0;
    endtask

    initial begin
        int seq[7];
        seq = '{0, 0, 1, 2, 2, 2, 3};

        rst     = 1'b1;
        flush   = 1'b0;
        out_hs  = 2'b00;
        out_idx = 4'h0;
        set_w(4'd2, 4'd1, 4'd3, 4'd1);

        // Reset values
        #1;
        check("rst_l0", rr[1:0], 2'd0);
        check("rst_l1", rr[3:2], 2'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        step(1'b0, 2'd0, 1'b0, 2'd0, 1'b0);
        check("post_rst_l0", rr[1:0], 2'd0);
        check("post_rst_l1", rr[3:2], 2'd0);

        // Weights {2,1,3,1}: two full periods of the 7-transfer rotation on lane 0
        for (int k = 0; k < 14; k++) begin
            step(1'b1, 2'(seq[k % 7]), 1'b0, 2'd0, 1'b0);
            check("wrr_seq_l0", rr[1:0], 2'(seq[(k + 1) % 7]));
            check("wrr_seq_l1_idle", rr[3:2], 2'd0);
        end

        // Weights {1,0,1,0}: zero-weight inputs are skipped and cannot steal priority
        set_w(4'd1, 4'd0, 4'd1, 4'd0);
        step(1'b0, 2'd0, 1'b0, 2'd0, 1'b1);
        step(1'b1, 2'd0, 1'b0, 2'd0, 1'b0);
        check("skip_zero", rr[1:0], 2'd2);
        step(1'b1, 2'd1, 1'b0, 2'd0, 1'b0);
        check("zero_winner_hold", rr[1:0], 2'd2);
        step(1'b1, 2'd2, 1'b0, 2'd0, 1'b0);
        check("wrap_after_skip", rr[1:0], 2'd0);

        // Bypass by a weight-3 input starts a burst at count 1
        set_w(4'd1, 4'd1, 4'd1, 4'd3);
        step(1'b0, 2'd0, 1'b0, 2'd0, 1'b1);
        step(1'b1, 2'd0, 1'b0, 2'd0, 1'b0);
        check("ptr_to_1", rr[1:0], 2'd1);
        step(1'b1, 2'd3, 1'b0, 2'd0, 1'b0);
        check("bypass_w3", rr[1:0], 2'd3);
        step(1'b1, 2'd3, 1'b0, 2'd0, 1'b0);
        check("burst_w3_mid", rr[1:0], 2'd3);
        step(1'b1, 2'd3, 1'b0, 2'd0, 1'b0);
        check("burst_w3_end", rr[1:0], 2'd0);

        // Bypass by a weight-1 input rotates past the winner
        set_w(4'd1, 4'd1, 4'd1, 4'd1);
        step(1'b1, 2'd2, 1'b0, 2'd0, 1'b0);
        check("bypass_w1", rr[1:0], 2'd3);

        // Weight lowered below the running count forces rotation
        set_w(4'd1, 4'd1, 4'd1, 4'd3);
        step(1'b0, 2'd0, 1'b0, 2'd0, 1'b1);
        step(1'b1, 2'd3, 1'b0, 2'd0, 1'b0);
        step(1'b1, 2'd3, 1'b0, 2'd0, 1'b0);
        check("cnt2_hold", rr[1:0], 2'd3);
        set_w(4'd1, 4'd1, 4'd1, 4'd1);
        step(1'b1, 2'd3, 1'b0, 2'd0, 1'b0);
        check("weight_drop", rr[1:0], 2'd0);

        // All weights zero: random handshakes never move either lane
        set_w(4'd0, 4'd0, 4'd0, 4'd0);
        for (int k = 0; k < 10; k++) begin
            step(1'b1, 2'($urandom_range(0, 3)), 1'b1, 2'($urandom_range(0, 3)), 1'b0);
            check("all_zero_l0", rr[1:0], 2'd0);
            check("all_zero_l1", rr[3:2], 2'd0);
        end

        // Flush overrides a same-cycle handshake and clears the burst count
        set_w(4'd2, 4'd1, 4'd3, 4'd1);
        step(1'b1, 2'd2, 1'b0, 2'd0, 1'b0);
        check("mid_burst", rr[1:0], 2'd2);
        step(1'b1, 2'd2, 1'b0, 2'd0, 1'b1);
        check("flush_over_hs", rr[1:0], 2'd0);
        step(1'b1, 2'd0, 1'b0, 2'd0, 1'b0);
        check("flush_cnt_clear", rr[1:0], 2'd0);

        // Asynchronous reset mid-burst
        step(1'b1, 2'd2, 1'b1, 2'd2, 1'b0);
        check("pre_arst_l0", rr[1:0], 2'd2);
        check("pre_arst_l1", rr[3:2], 2'd2);
        #3;
        rst = 1'b1;
        #1;
        check("arst_now_l0", rr[1:0], 2'd0);
        check("arst_now_l1", rr[3:2], 2'd0);
        #2;
        rst = 1'b0;
        step(1'b0, 2'd0, 1'b0, 2'd0, 1'b0);
        check("arst_hold", rr[1:0], 2'd0);
        step(1'b1, 2'd0, 1'b0, 2'd0, 1'b0);
        check("arst_cnt_clear", rr[1:0], 2'd0);
        step(1'b1, 2'd0, 1'b0, 2'd0, 1'b0);
        check("arst_burst_end", rr[1:0], 2'd1);

        // Two lanes with interleaved handshakes, weights {2,1,3,1}
        step(1'b0, 2'd0, 1'b0, 2'd0, 1'b1);
        step(1'b1, 2'd0, 1'b1, 2'd2, 1'b0);
        check("dual1_l0", rr[1:0], 2'd0);
        check("dual1_l1", rr[3:2], 2'd2);
        step(1'b1, 2'd0, 1'b0, 2'd0, 1'b0);
        check("dual2_l0", rr[1:0], 2'd1);
        check("dual2_l1", rr[3:2], 2'd2);
        step(1'b0, 2'd0, 1'b1, 2'd2, 1'b0);
        check("dual3_l0", rr[1:0], 2'd1);
        check("dual3_l1", rr[3:2], 2'd2);
        step(1'b1, 2'd1, 1'b1, 2'd2, 1'b0);
        check("dual4_l0", rr[1:0], 2'd2);
        check("dual4_l1", rr[3:2], 2'd3);
        step(1'b1, 2'd3, 1'b1, 2'd0, 1'b0);
        check("dual5_l0", rr[1:0], 2'd0);
        check("dual5_l1", rr[3:2], 2'd0);
        step(1'b0, 2'd0, 1'b1, 2'd0, 1'b0);
        check("dual6_l0", rr[1:0], 2'd0);
        check("dual6_l1", rr[3:2], 2'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
